// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered MDU results.
// Starved MDU results force a one-cycle pipeline stall to drain the FIFO head.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_reg_write_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            mdu_issue_i,
  input  logic [4:0]      mdu_issue_rd_i,
  input  logic            mdu_valid_i,
  input  logic [4:0]      mdu_rd_i,
  input  logic [XLEN-1:0] mdu_data_i,
  output logic            mdu_ready_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            pipe_stall_o,
  output logic [31:0]     busy_mask_o,
  output logic [CW-1:0]   fifo_count_o
);

  typedef enum logic {NORMAL, STALL} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic            empty, full, push, pop, pipe_write;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [31:0]     set_m, clr_m;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    push       = mdu_valid_i & ~full;
    head_rd    = rd_mem_q[rptr_q];
    head_data  = data_mem_q[rptr_q];
    pipe_write = wb_reg_write_i & (wb_rd_i != 5'd0);
    cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    pop          = 1'b0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    pipe_stall_o = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      NORMAL: begin
        if (pipe_write) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = wb_rd_i;
          rf_wdata_o = wb_data_i;
        end else if (!empty) begin
          pop        = 1'b1;
          rf_we_o    = (head_rd != 5'd0);
          rf_waddr_o = head_rd;
          rf_wdata_o = head_data;
        end
        if (pop || empty) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(STARVE_LIMIT)) state_d = STALL;
        end
      end
      STALL: begin
        // The frozen MEM/WB replays its request, so it is safe to ignore it here.
        pipe_stall_o = 1'b1;
        pop          = ~empty;
        if (!empty) begin
          rf_we_o    = (head_rd != 5'd0);
          rf_waddr_o = head_rd;
          rf_wdata_o = head_data;
        end
        cnt_d   = '0;
        state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    if (!resetn) begin
      rf_we_o      = 1'b0;
      rf_waddr_o   = '0;
      rf_wdata_o   = '0;
      pipe_stall_o = 1'b0;
    end

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    set_m  = (mdu_issue_i && mdu_issue_rd_i != 5'd0) ? (32'd1 << mdu_issue_rd_i) : '0;
    clr_m  = pop ? (32'd1 << head_rd) : '0;
    busy_d = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;

    mdu_ready_o  = ~full;
    busy_mask_o  = busy_q;
    fifo_count_o = count_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      rd_mem_q[wptr_q]   <= mdu_rd_i;
      data_mem_q[wptr_q] <= mdu_data_i;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes queued by stimulus,
// checked by a negedge monitor; state outputs checked directly.
module tb_wb_port_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            wb_reg_write_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            mdu_issue_i;
  logic [4:0]      mdu_issue_rd_i;
  logic            mdu_valid_i;
  logic [4:0]      mdu_rd_i;
  logic [XLEN-1:0] mdu_data_i;
  logic            mdu_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            pipe_stall_o;
  logic [31:0]     busy_mask_o;
  logic [1:0]      fifo_count_o;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_reg_write_i (wb_reg_write_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .mdu_issue_i    (mdu_issue_i),
    .mdu_issue_rd_i (mdu_issue_rd_i),
    .mdu_valid_i    (mdu_valid_i),
    .mdu_rd_i       (mdu_rd_i),
    .mdu_data_i     (mdu_data_i),
    .mdu_ready_o    (mdu_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pipe_stall_o   (pipe_stall_o),
    .busy_mask_o    (busy_mask_o),
    .fifo_count_o   (fifo_count_o)
  );

  typedef struct packed {
    logic        stall;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic s, input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({s, rd, d});
  endtask

  task automatic drv(input logic we, input logic [4:0] rd, input logic [31:0] d,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic iss, input logic [4:0] ird);
    wb_reg_write_i = we;
    wb_rd_i        = rd;
    wb_data_i      = d;
    mdu_valid_i    = mv;
    mdu_rd_i       = mrd;
    mdu_data_i     = md;
    mdu_issue_i    = iss;
    mdu_issue_rd_i = ird;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rf_we_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h stall=%0b, expected no write",
                 rf_waddr_o, rf_wdata_o, pipe_stall_o);
      end else begin
        e = exp_q.pop_front();
        if ({pipe_stall_o, rf_waddr_o, rf_wdata_o} !== e) begin
          miscompares++;
          $display("FAIL write: got stall=%0b rd=%0d data=%0h expected stall=%0b rd=%0d data=%0h",
                   pipe_stall_o, rf_waddr_o, rf_wdata_o, e.stall, e.rd, e.data);
        end
      end
    end else if (pipe_stall_o) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_no_write: got stall=1 with rf_we=0, expected a head write");
    end
    if (resetn && mdu_issue_i && mdu_issue_rd_i != 0) begin
      vectors++;
      if (busy_mask_o[mdu_issue_rd_i]) begin
        miscompares++;
        $display("FAIL issue_busy: got issue to busy x%0d, expected free rd", mdu_issue_rd_i);
      end
    end
    if (resetn && wb_reg_write_i && wb_rd_i != 0 && !pipe_stall_o) begin
      vectors++;
      if (busy_mask_o[wb_rd_i]) begin
        miscompares++;
        $display("FAIL pipe_busy: got pipeline write to busy x%0d, expected free rd", wb_rd_i);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle();
    tick();
    drv(1, 5, 32'h1111, 0, 0, 0, 0, 0);
    #1;
    chk("we_in_reset", rf_we_o, 0);
    tick();
    resetn = 1'b1;
    idle();
    #1;
    chk("rst_count", fifo_count_o, 0);
    chk("rst_mask", busy_mask_o, 0);
    chk("rst_ready", mdu_ready_o, 1);
    chk("rst_stall", pipe_stall_o, 0);
    chk("rst_we", rf_we_o, 0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);

    // pipeline only
    drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expw(0, 5, 32'hDEADBEEF);
    tick();

    // single MDU op to x7
    drv(0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    idle();
    chk("t2_busy_c1", busy_mask_o[7], 1);
    tick();
    tick();
    drv(0, 0, 0, 1, 7, 32'h12, 0, 0);
    chk("t2_ready_c3", mdu_ready_o, 1);
    tick();
    idle();
    chk("t2_count_c4", fifo_count_o, 1);
    chk("t2_busy_c4", busy_mask_o[7], 1);
    expw(0, 7, 32'h12);
    tick();
    chk("t2_busy_c5", busy_mask_o, 0);
    chk("t2_count_c5", fifo_count_o, 0);

    // x0 writes
    drv(1, 0, 32'hAAAA, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 0, 32'h55, 1, 0);
    tick();
    idle();
    chk("t3_count_push", fifo_count_o, 1);
    chk("t3_mask_x0", busy_mask_o, 0);
    tick();
    chk("t3_count_pop", fifo_count_o, 0);

    // starvation forces one stall
    drv(0, 0, 0, 0, 0, 0, 1, 12);
    tick();
    drv(1, 10, 32'h100, 1, 12, 32'hC0, 0, 0);
    expw(0, 10, 32'h100);
    tick();
    drv(1, 11, 32'h101, 0, 0, 0, 0, 0); expw(0, 11, 32'h101); tick();
    drv(1, 13, 32'h102, 0, 0, 0, 0, 0); expw(0, 13, 32'h102); tick();
    drv(1, 14, 32'h103, 0, 0, 0, 0, 0); expw(0, 14, 32'h103); tick();
    chk("t4_no_stall_b4", pipe_stall_o, 0);
    drv(1, 15, 32'h104, 0, 0, 0, 0, 0); expw(0, 15, 32'h104); tick();
    chk("t4_stall", pipe_stall_o, 1);
    drv(1, 16, 32'h105, 0, 0, 0, 0, 0);
    expw(1, 12, 32'hC0);
    tick();
    chk("t4_stall_off", pipe_stall_o, 0);
    chk("t4_mask_clr", busy_mask_o, 0);
    expw(0, 16, 32'h105);
    tick();
    idle();

    // three back-to-back MDU results, DEPTH=2
    drv(0, 0, 0, 0, 0, 0, 1, 20); tick();
    drv(0, 0, 0, 0, 0, 0, 1, 21); tick();
    drv(0, 0, 0, 0, 0, 0, 1, 22); tick();
    drv(1, 1, 32'h200, 1, 20, 32'hA0, 0, 0); expw(0, 1, 32'h200); tick();
    chk("t5_ready_c1", mdu_ready_o, 1);
    drv(1, 2, 32'h201, 1, 21, 32'hA1, 0, 0); expw(0, 2, 32'h201); tick();
    chk("t5_ready_full", mdu_ready_o, 0);
    chk("t5_count_full", fifo_count_o, 2);
    drv(1, 3, 32'h202, 1, 22, 32'hA2, 0, 0); expw(0, 3, 32'h202); tick();
    drv(1, 4, 32'h203, 1, 22, 32'hA2, 0, 0); expw(0, 4, 32'h203); tick();
    drv(1, 5, 32'h204, 1, 22, 32'hA2, 0, 0); expw(0, 5, 32'h204); tick();
    chk("t5_stall1", pipe_stall_o, 1);
    chk("t5_ready_stall", mdu_ready_o, 0);
    drv(1, 6, 32'h205, 1, 22, 32'hA2, 0, 0); expw(1, 20, 32'hA0); tick();
    chk("t5_count_after_pop", fifo_count_o, 1);
    chk("t5_ready_again", mdu_ready_o, 1);
    drv(1, 6, 32'h205, 1, 22, 32'hA2, 0, 0); expw(0, 6, 32'h205); tick();
    chk("t5_count_third", fifo_count_o, 2);
    drv(1, 7, 32'h206, 0, 0, 0, 0, 0); expw(0, 7, 32'h206); tick();
    drv(1, 8, 32'h207, 0, 0, 0, 0, 0); expw(0, 8, 32'h207); tick();
    drv(1, 9, 32'h208, 0, 0, 0, 0, 0); expw(0, 9, 32'h208); tick();
    chk("t5_stall2", pipe_stall_o, 1);
    drv(1, 17, 32'h209, 0, 0, 0, 0, 0); expw(1, 21, 32'hA1); tick();
    drv(1, 17, 32'h209, 0, 0, 0, 0, 0); expw(0, 17, 32'h209); tick();
    idle();
    expw(0, 22, 32'hA2);
    tick();
    chk("t5_count_end", fifo_count_o, 0);
    chk("t5_mask_end", busy_mask_o, 0);

    // reset with FIFO full and busy bits pending
    drv(0, 0, 0, 0, 0, 0, 1, 3); tick();
    drv(0, 0, 0, 0, 0, 0, 1, 9); tick();
    drv(1, 4, 32'h300, 1, 3, 32'h33, 0, 0); expw(0, 4, 32'h300); tick();
    drv(1, 5, 32'h301, 1, 9, 32'h99, 0, 0); expw(0, 5, 32'h301); tick();
    chk("t6_count_pre", fifo_count_o, 2);
    chk("t6_mask_pre", busy_mask_o, 32'h0000_0208);
    resetn = 1'b0;
    drv(1, 6, 32'h302, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    idle();
    chk("t6_count", fifo_count_o, 0);
    chk("t6_mask", busy_mask_o, 0);
    chk("t6_ready", mdu_ready_o, 1);
    chk("t6_stall", pipe_stall_o, 0);
    tick();
    tick();
    tick();
    chk("t6_no_stall_later", pipe_stall_o, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
